// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with a valid/ready handshake on both sides.
//               ADD/SUB complete one cycle after acceptance; shifts move the
//               working register one bit per cycle (k+1 cycles of latency for
//               a shift count k); illegal modes complete immediately with Err.
// Ports       : Clk, Reset              - clock, synchronous active-high reset
//               InValid/InReady         - request handshake (ready only in IDLE)
//               A, B, Cin, Mode         - operands, carry-in, operation select
//               OutValid/OutReady       - result handshake (valid only in DONE)
//               Result, Cout, Overflow,
//               Zero, Err               - registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Err
);

  localparam logic [2:0] c_MODE_ADD = 3'b000;
  localparam logic [2:0] c_MODE_SUB = 3'b001;
  localparam logic [2:0] c_MODE_SLL = 3'b010;
  localparam logic [2:0] c_MODE_SRL = 3'b011;
  localparam logic [2:0] c_MODE_SRA = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_nextState;
  logic [WIDTH-1:0] r_work,  w_work;
  logic             r_cout,  w_cout;
  logic             r_ovf,   w_ovf;
  logic             r_err,   w_err;
  logic [SHW-1:0]   r_cnt,   w_cnt;
  logic [2:0]       r_mode,  w_mode;

  // One extra bit on each sum so bit WIDTH is the carry-out.  For SUB the
  // carry-out of A + ~B + 1 is exactly the "no borrow" (A >= B) indication.
  logic [WIDTH:0]   w_addSum;
  logic [WIDTH:0]   w_subSum;
  logic [SHW-1:0]   w_shAmt;

  assign w_addSum = {1'b0, A} + {1'b0, B}  + {{WIDTH{1'b0}}, Cin};
  assign w_subSum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shAmt  = B[SHW-1:0];

  always_comb begin
    w_nextState = r_state;
    w_work      = r_work;
    w_cout      = r_cout;
    w_ovf       = r_ovf;
    w_err       = r_err;
    w_cnt       = r_cnt;
    w_mode      = r_mode;

    case (r_state)
      S_IDLE: begin
        if (InValid) begin
          w_mode = Mode;
          w_cout = 1'b0;
          w_ovf  = 1'b0;
          w_err  = 1'b0;
          w_cnt  = '0;
          case (Mode)
            c_MODE_ADD: begin
              w_work      = w_addSum[WIDTH-1:0];
              w_cout      = w_addSum[WIDTH];
              w_ovf       = (A[WIDTH-1] == B[WIDTH-1]) &&
                            (w_addSum[WIDTH-1] != A[WIDTH-1]);
              w_nextState = S_DONE;
            end
            c_MODE_SUB: begin
              // Operand signs compared with B inverted, as it enters the adder.
              w_work      = w_subSum[WIDTH-1:0];
              w_cout      = w_subSum[WIDTH];
              w_ovf       = (A[WIDTH-1] != B[WIDTH-1]) &&
                            (w_subSum[WIDTH-1] != A[WIDTH-1]);
              w_nextState = S_DONE;
            end
            c_MODE_SLL, c_MODE_SRL, c_MODE_SRA: begin
              w_work = A;
              if (w_shAmt == '0) begin
                w_nextState = S_DONE;
              end else begin
                w_cnt       = w_shAmt;
                w_nextState = S_SHIFT;
              end
            end
            default: begin
              w_work      = '0;
              w_err       = 1'b1;
              w_nextState = S_DONE;
            end
          endcase
        end
      end

      S_SHIFT: begin
        case (r_mode)
          c_MODE_SLL: begin
            w_work = {r_work[WIDTH-2:0], 1'b0};
            w_cout = r_work[WIDTH-1];
          end
          c_MODE_SRL: begin
            w_work = {1'b0, r_work[WIDTH-1:1]};
            w_cout = r_work[0];
          end
          default: begin
            w_work = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            w_cout = r_work[0];
          end
        endcase
        w_cnt = r_cnt - SHW'(1);
        // Counter is about to hit zero: this is the last shift step.
        if (r_cnt == SHW'(1)) begin
          w_nextState = S_DONE;
        end
      end

      S_DONE: begin
        if (OutReady) begin
          w_nextState = S_IDLE;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= c_MODE_ADD;
    end else begin
      r_state <= w_nextState;
      r_work  <= w_work;
      r_cout  <= w_cout;
      r_ovf   <= w_ovf;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
    end
  end

  assign InReady  = (r_state == S_IDLE);
  assign OutValid = (r_state == S_DONE);
  assign Result   = r_work;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;
  assign Err      = r_err;
  assign Zero     = (r_work == '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Randomized scoreboard bench for seq_alu (WIDTH = 32).
//               A reference model computes each expected response with plain
//               arithmetic when the request is issued; a monitor compares every
//               OutValid cycle, including first-valid latency and stability
//               while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A, B;
  logic             Cin;
  logic [2:0]       Mode;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Cout, Overflow, Zero, Err;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Mode     (Mode),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Zero     (Zero),
    .Err      (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        err;
    longint      firstCyc;
  } exp_t;

  exp_t   q[$];
  exp_t   mon;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     seen = 0;
  bit     holdLow = 0;
  bit     forceHigh = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: expected response and latency straight from the
  // arithmetic definitions of each mode.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic [2:0] mode);
    exp_t   r;
    longint us, ss;
    int     k;
    logic signed [31:0] sr;
    r.res = '0; r.cout = 1'b0; r.ovf = 1'b0; r.err = 1'b0; r.firstCyc = 1;
    k = int'(b[4:0]);
    case (mode)
      3'd0: begin
        us = longint'(a) + longint'(b) + longint'(cin);
        ss = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.res  = us[31:0];
        r.cout = (us > 64'sd4294967295);
        r.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd1: begin
        ss = longint'($signed(a)) - longint'($signed(b));
        r.res  = a - b;
        r.cout = (a >= b);
        r.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd2: begin
        r.res  = a << k;
        r.cout = (k != 0) ? a[32-k] : 1'b0;
        r.firstCyc = k + 1;
      end
      3'd3: begin
        r.res  = a >> k;
        r.cout = (k != 0) ? a[k-1] : 1'b0;
        r.firstCyc = k + 1;
      end
      3'd4: begin
        sr     = $signed(a) >>> k;
        r.res  = sr;
        r.cout = (k != 0) ? a[k-1] : 1'b0;
        r.firstCyc = k + 1;
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Consumer: random backpressure unless a test pins OutReady.
  initial begin
    OutReady = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      OutReady = holdLow ? 1'b0 : (forceHigh ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // Monitor: compares every cycle in which a result is presented.
  always @(negedge Clk) begin
    if (Reset) begin
      seen = 0;
    end else if (OutValid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outvalid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon = q[0];
        if (!seen) begin
          seen = 1;
          chk("latency", cyc, mon.firstCyc);
        end
        chk("result",   Result,   mon.res);
        chk("cout",     Cout,     mon.cout);
        chk("overflow", Overflow, mon.ovf);
        chk("err",      Err,      mon.err);
        chk("zero",     Zero,     (mon.res == 32'd0));
        chk("inready_busy", InReady, 1'b0);
        if (OutReady) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Wait for the block to be ready (driving ignored garbage meanwhile), then
  // present one request and release it right after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [2:0] mode, input bit track);
    exp_t e;
    int   waited = 0;
    @(negedge Clk);
    while (!InReady) begin
      InValid = 1'($urandom);
      A = $urandom; B = $urandom; Cin = 1'($urandom); Mode = 3'($urandom);
      waited++;
      if (waited > 500) begin
        $display("FAIL ready_timeout actual=0 expected=1");
        errors++;
        $fatal(1, "InReady never returned");
      end
      @(negedge Clk);
    end
    InValid = 1'b1; A = a; B = b; Cin = cin; Mode = mode;
    if (track) begin
      e = model(a, b, cin, mode);
      e.firstCyc = cyc + e.firstCyc;
      q.push_back(e);
    end
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom); Mode = 3'($urandom);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; A = '0; B = '0; Cin = 1'b0; Mode = 3'd0;
    repeat (3) @(negedge Clk);
    chk("rst_inready",  InReady,  1'b1);
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_result",   Result,   32'd0);
    chk("rst_cout",     Cout,     1'b0);
    chk("rst_overflow", Overflow, 1'b0);
    chk("rst_err",      Err,      1'b0);
    Reset = 1'b0;

    // Boundary cases
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b000, 1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 3'b001, 1);
    issue(32'h0000_0001, 32'h0000_0002, 1'b1, 3'b001, 1);
    issue(32'h8000_0001, 32'h0000_0004, 1'b0, 3'b100, 1);
    issue(32'h0000_0001, 32'h0000_0000, 1'b0, 3'b010, 1);
    issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 3'b000, 1);
    issue(32'hDEAD_BEEF, 32'h0000_001F, 1'b0, 3'b011, 1);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 3'b110, 1);
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 3'b000, 1);

    // Consumer stall: result must hold and no new request may be taken.
    holdLow = 1;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 3'b000, 1);
    repeat (3) begin
      @(negedge Clk);
      InValid = ~InValid;
      A = $urandom;
    end
    holdLow = 0;
    forceHigh = 1;
    @(negedge Clk);
    InValid = 1'b0;
    @(negedge Clk);
    chk("idle_after_handshake", InReady,  1'b1);
    chk("no_valid_after_hs",    OutValid, 1'b0);
    forceHigh = 0;

    // Reset during the third shift cycle of SLL by 10 aborts the operation.
    issue(32'h0000_00FF, 32'd10, 1'b0, 3'b010, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_inready",  InReady,  1'b1);
    chk("abort_outvalid", OutValid, 1'b0);
    chk("abort_result",   Result,   32'd0);
    chk("abort_cout",     Cout,     1'b0);
    chk("abort_overflow", Overflow, 1'b0);
    chk("abort_err",      Err,      1'b0);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rm;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      rm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      issue(ra, rb, 1'($urandom), rm, 1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    // Drain outstanding results.
    forceHigh = 1;
    for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge Clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width; legal range 8..64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 Port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port InValid  input  1  operation request valid.
REQ-006 Port InReady  output  1  block can accept an operation.
REQ-007 Port A  input  WIDTH  first operand; the value shifted by shift modes.
REQ-008 Port B  input  WIDTH  second operand; B[SHW-1:0] is the shift amount in shift modes.
REQ-009 Port Cin  input  1  carry-in, used by ADD only.
REQ-010 Port Mode  input  3  000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA; 101-111 illegal.
REQ-011 Port OutValid  output  1  Result and flags valid.
REQ-012 Port OutReady  input  1  consumer accepts the result.
REQ-013 Port Result  output  WIDTH  operation result.
REQ-014 Port Cout  output  1  carry-out, or last bit shifted out.
REQ-015 Port Overflow  output  1  signed overflow, ADD/SUB only.
REQ-016 Port Zero  output  1  Result == 0.
REQ-017 Port Err  output  1  illegal Mode was accepted.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, DONE; InReady = 1 only in IDLE.
REQ-019 An operation SHALL be accepted on the edge where InValid && InReady; A, B, Cin and Mode are captured then; input changes afterwards have no effect.
REQ-020 ADD: Result = A+B+Cin mod 2^WIDTH, Cout = bit WIDTH of the sum; IDLE->DONE; OutValid asserts the cycle after acceptance.
REQ-021 SUB: Result = A+~B+1 mod 2^WIDTH, Cout = 1 iff A >= B unsigned (no borrow); Cin ignored; latency as ADD.
REQ-022 Overflow SHALL be 1 iff operand signs (B inverted for SUB) agree and differ from the Result sign; Overflow = 0 for shifts.
REQ-023 Shifts: shift count k = B[SHW-1:0]; if k == 0, IDLE->DONE with Result = A and Cout = 0; otherwise IDLE->SHIFT.
REQ-024 In SHIFT, each cycle SHALL shift the working register one bit (SLL fill 0, SRL fill 0, SRA fill sign bit), set Cout to the bit shifted out, and decrement the counter; on the cycle the counter reaches 0, go to DONE.
REQ-025 Shift latency SHALL be k+1 cycles from the accept edge to the first OutValid.
REQ-026 Illegal Mode: IDLE->DONE with Result = 0, Cout = 0, Overflow = 0, Err = 1; Err is 0 for all legal modes.
REQ-027 Zero SHALL be combinational on the registered Result and is meaningful only while OutValid = 1.
REQ-028 In DONE, OutValid = 1; Result and all flags SHALL stay stable until OutValid && OutReady, then go to IDLE on the next edge.
REQ-029 InValid asserted outside IDLE SHALL be ignored; no queuing. Minimum spacing between accepts is 2 cycles.
REQ-030 OutReady held high already in the DONE-entry cycle SHALL complete the handshake in that cycle.

Reset
REQ-031 Reset SHALL force IDLE on the next edge, with InReady = 1, OutValid = 0, Result = 0, Cout = 0, Overflow = 0, Err = 0, and the shift counter cleared.
REQ-032 Reset mid-SHIFT or in DONE SHALL abort the operation with no OutValid pulse; Reset has priority over accept.

Verification (WIDTH=32)
REQ-033 ADD A=FFFFFFFF, B=00000001, Cin=0 -> one cycle later: Result=0, Cout=1, Zero=1, Overflow=0.
REQ-034 SUB A=80000000, B=00000001 -> Result=7FFFFFFF, Cout=1, Overflow=1; SUB A=1, B=2 -> Result=FFFFFFFF, Cout=0.
REQ-035 SRA A=80000001, B=4 -> OutValid exactly 5 cycles after accept, Result=F8000000, Cout=0; SLL A=1, B=0 -> Result=1 after 1 cycle.
REQ-036 Hold OutReady=0 for 3 cycles in DONE, toggling InValid/A -> Result stable, InReady=0, no second accept; OutReady=1 -> IDLE next cycle.
REQ-037 Mode=110 -> Err=1, Result=0, Zero=1; following legal ADD -> Err=0.
REQ-038 Reset asserted on the 3rd SHIFT cycle of SLL by 10 -> IDLE, all outputs 0, InReady=1, no OutValid.
